lane_error_injector: RTL and testbench
======================================

# lane_error_injector

Multi-lane, single-clock error injector for differential serial-link benches. It is the successor to the single-lane random injector: a parametrised lane count, deterministic LFSR-based random injection, burst and single-shot modes, a lane mask, and per-lane saturating error counters. It sits between a transmitter model's differential outputs and the channel/receiver model, flipping both legs of a lane together so that polarity is inverted and the pair stays complementary.

## Interface
- LANES, 4, number of differential lanes (1–32)
- CNT_W, 32, width of each per-lane error counter
- SEED, 16'hACE1, LFSR reset value; must be nonzero
- clock  in  1  sole clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- in_p, in_n  in  LANES  differential lane inputs
- out_p, out_n  out  LANES  outputs: `in_p ^ inject`, `in_n ^ inject`, bitwise per lane
- mode  in  2  0 OFF, 1 RANDOM, 2 BURST, 3 SINGLE
- lane_mask  in  LANES  1 = lane eligible for injection
- rate  in  16  RANDOM threshold; probability = rate/65536
- burst_len  in  8  BURST: inject cycles per period
- burst_period  in  16  BURST: period length in cycles
- trigger  in  1  SINGLE: request a one-cycle injection
- stop  in  1  suppress all injection
- clear  in  1  synchronous zeroing of counters
- busy  out  1  high while a BURST period or SINGLE shot is in progress
- errors  out  LANES*CNT_W  lane i counter at bits [i*CNT_W +: CNT_W] (only with LANE_ERROR_INJECTOR_COUNT_EN)

## Operation
- The `inject[LANES-1:0]` register is the only source of injection. The output XOR is combinational on that register.
- Every lane's inject bit is forced to 0 when `lane_mask[i]` = 0, `stop` = 1, or `mode` = OFF.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle out of reset, regardless of mode.
  - Lane i compares `rotl(lfsr, 3*i mod 16)`.
- RANDOM: lane i injects when its rotated value is less than `rate`.
  - `rate` = 0 never injects; `rate` = 16'hFFFF injects on 65535/65536 of cycles.
- BURST: phase counter `ph` counts 0..burst_period-1, then wraps to 0. All unmasked lanes inject while `ph` < `burst_len`.
  - `burst_len` = 0: never injects.
  - `burst_len` ≥ `burst_period`: continuous injection.
  - `burst_period` = 0 is treated as 1.
- SINGLE uses an FSM with states ARMED, SHOT, HOLD:
  - ARMED with `trigger` = 1 goes to SHOT; inject = lane_mask for exactly one cycle.
  - SHOT goes to HOLD.
  - HOLD goes to ARMED once `trigger` = 0. Edge-based, so a held trigger gives exactly one shot.
  - `trigger` during SHOT or HOLD is ignored.
- `busy`:
  - SINGLE: 1 in SHOT.
  - BURST: 1 while `ph` < `burst_len`.
  - Otherwise 0.
- A change of `mode`, or `stop` = 1, resets `ph` to 0 and the SINGLE FSM to ARMED on the next edge. `stop` has priority over `trigger`.
- Counters:
  - `errors[i]` increments by 1 each cycle `inject[i]` = 1.
  - Counters saturate at all-ones.
  - `clear` has priority over increment.
  - Counters hold while `stop` = 1.

## Timing
- Reset (reset_n low, asynchronous):
  - inject = 0, so out_p/out_n = in_p/in_n.
  - busy = 0, errors = 0, lfsr = SEED, ph = 0, FSM = ARMED.
- Latency: control sampled at edge t affects outputs after edge t+1. Example: `trigger` high at edge t gives inject during cycle t+1 to t+2.
- A counter reflects an injection in the cycle after `inject` goes high.
- Deassertion of reset_n is expected synchronised externally. The first LFSR advance happens on the first edge after deassertion.
- Reset asserted mid-burst or mid-shot immediately clears inject; nothing is retained.

## Configuration
- LANE_ERROR_INJECTOR_COUNT_EN:
  - Defined: per-lane counters, `clear` and `errors` are present.
  - Undefined: no counter logic, `errors` is absent from the port list, `clear` is unused.
  - Injection behaviour is identical either way.

## Structure
- Package `lane_error_injector_pkg`:
  - `mode_t` enum (OFF/RANDOM/BURST/SINGLE)
  - SINGLE FSM state enum
  - LFSR polynomial constant (16'hB400)
  - `rotl` function
- One natural sub-module, `lfsr16`: SEED parameter, with clock, reset_n and value out.
- Per-lane compare and counter logic lives in a generate loop in the top module.

## Test plan
- RANDOM, rate = 0, LANES = 4, all-mask, 10k cycles: out equals in throughout; errors all 0.
- RANDOM, rate = 16'h4000, 65536 cycles: each lane counter within 16384 ± 3%; outputs stay complementary when inputs are complementary.
- BURST, len = 3, period = 8, mask = 4'b0101: lanes 0 and 2 inverted on cycles 0–2 of every 8; lanes 1 and 3 never; busy matches; after 80 cycles, counters 0 and 2 = 30.
- SINGLE, trigger held 20 cycles, then pulsed again: exactly two one-cycle injections; counters = 2; trigger during HOLD is ignored.
- Saturation and clear, CNT_W = 4: continuous burst for 20 cycles gives errors = 15 and holds there; clear together with inject gives 0 that cycle, then resumes counting at 1.
- reset_n low mid-burst: outputs follow inputs in the same cycle; busy = 0; after release, the LFSR sequence restarts from SEED and matches the golden first 4 values.

Source files
------------

// File: rtl/lane_error_injector_pkg.sv
// Shared types and helpers for the multi-lane differential error injector.
package lane_error_injector_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_RANDOM = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_SINGLE = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_SHOT  = 2'd1,
    ST_HOLD  = 2'd2
  } single_st_t;

  // Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] rotl(input logic [15:0] v, input logic [3:0] sh);
    logic [31:0] d;
    d = {v, v} << sh;
    return d[31:16];
  endfunction

endpackage

// File: rtl/lane_error_injector_lfsr16.sv
// Free-running 16-bit Galois LFSR; loads SEED in reset and steps every clock.
module lfsr16
  import lane_error_injector_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] value
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= SEED;
    end else if (value[0]) begin
      value <= (value >> 1) ^ LFSR_POLY;
    end else begin
      value <= value >> 1;
    end
  end

endmodule

// File: rtl/lane_error_injector.sv
// Multi-lane differential error injector (RANDOM / BURST / SINGLE, lane mask).
// Per-lane saturating error counters are built only with LANE_ERROR_INJECTOR_COUNT_EN.
module lane_error_injector
  import lane_error_injector_pkg::*;
#(
  parameter int          LANES = 4,
  parameter int          CNT_W = 32,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [LANES-1:0]       in_p,
  input  logic [LANES-1:0]       in_n,
  output logic [LANES-1:0]       out_p,
  output logic [LANES-1:0]       out_n,
  input  logic [1:0]             mode,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [15:0]            rate,
  input  logic [7:0]             burst_len,
  input  logic [15:0]            burst_period,
  input  logic                   trigger,
  input  logic                   stop,
  input  logic                   clear,
  output logic                   busy
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
  ,
  output logic [LANES*CNT_W-1:0] errors
`endif
);

  mode_t            mode_p0;
  logic [LANES-1:0] mask_p0;
  logic [15:0]      rate_p0;
  logic [7:0]       len_p0;
  logic [15:0]      period_p0;
  logic             trig_p0;
  logic             stop_p0;

  mode_t            mode_p1;
  logic [15:0]      ph_p1;
  single_st_t       st_p1;
  logic [LANES-1:0] inject_p1;
  logic             busy_p1;

  logic [15:0]      lfsr_val;
  logic [15:0]      per_eff;
  logic [15:0]      ph_n;
  logic             burst_on;
  logic [LANES-1:0] rnd_hit;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clock  (clock),
    .reset_n(reset_n),
    .value  (lfsr_val)
  );

  // Stage 0: register all control inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_p0   <= MODE_OFF;
      mask_p0   <= '0;
      rate_p0   <= '0;
      len_p0    <= '0;
      period_p0 <= '0;
      trig_p0   <= 1'b0;
      stop_p0   <= 1'b0;
    end else begin
      mode_p0   <= mode_t'(mode);
      mask_p0   <= lane_mask;
      rate_p0   <= rate;
      len_p0    <= burst_len;
      period_p0 <= burst_period;
      trig_p0   <= trigger;
      stop_p0   <= stop;
    end
  end

  // Burst phase restarts on stop, on any mode change, and outside BURST
  always_comb begin
    per_eff = (period_p0 == 16'd0) ? 16'd1 : period_p0;
    ph_n    = 16'd0;
    if (!stop_p0 && mode_p0 == MODE_BURST && mode_p0 == mode_p1 &&
        ph_p1 < per_eff - 16'd1) begin
      ph_n = ph_p1 + 16'd1;
    end
  end

  assign burst_on = {8'd0, len_p0} > ph_n;

  for (genvar i = 0; i < LANES; i++) begin : g_rnd
    localparam logic [3:0] ROT = 4'((3 * i) % 16);
    assign rnd_hit[i] = rotl(lfsr_val, ROT) < rate_p0;
  end

  // Stage 1: phase, SINGLE FSM and the inject register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_p1   <= MODE_OFF;
      ph_p1     <= '0;
      st_p1     <= ST_ARMED;
      inject_p1 <= '0;
      busy_p1   <= 1'b0;
    end else begin
      mode_p1   <= mode_p0;
      ph_p1     <= ph_n;
      st_p1     <= ST_ARMED;
      inject_p1 <= '0;
      busy_p1   <= 1'b0;
      if (!stop_p0) begin
        unique case (mode_p0)
          MODE_RANDOM: inject_p1 <= rnd_hit & mask_p0;
          MODE_BURST: begin
            if (burst_on) begin
              inject_p1 <= mask_p0;
              busy_p1   <= 1'b1;
            end
          end
          MODE_SINGLE: begin
            if (mode_p0 == mode_p1) begin
              unique case (st_p1)
                ST_ARMED: begin
                  if (trig_p0) begin
                    st_p1     <= ST_SHOT;
                    inject_p1 <= mask_p0;
                    busy_p1   <= 1'b1;
                  end
                end
                ST_SHOT: st_p1 <= ST_HOLD;
                ST_HOLD: st_p1 <= trig_p0 ? ST_HOLD : ST_ARMED;
                default: st_p1 <= ST_ARMED;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_p = in_p ^ inject_p1;
  assign out_n = in_n ^ inject_p1;
  assign busy  = busy_p1;

`ifdef LANE_ERROR_INJECTOR_COUNT_EN
  for (genvar i = 0; i < LANES; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    // clear wins over increment; stop freezes the count
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (clear) begin
        cnt <= '0;
      end else if (!stop && inject_p1[i] && cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign errors[i*CNT_W +: CNT_W] = cnt;
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = {CNT_W{clear}};
`endif

endmodule

// File: tb/tb_lane_error_injector.sv
// Directed bench for lane_error_injector: vector table plus multi-cycle sequences.
module tb_lane_error_injector;

  localparam int LANES = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [LANES-1:0] in_p, in_n;
  logic [1:0]       mode;
  logic [LANES-1:0] lane_mask;
  logic [15:0]      rate;
  logic [7:0]       burst_len;
  logic [15:0]      burst_period;
  logic             trigger, stop, clear;

  logic [LANES-1:0] out_p, out_n, out_p4, out_n4;
  logic             busy, busy4;
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
  logic [LANES*32-1:0] err_main;
  logic [LANES*4-1:0]  err_sat;
`endif

  int checks = 0;
  int err_cnt = 0;

  lane_error_injector #(.LANES(LANES), .CNT_W(32), .SEED(16'hACE1)) dut (
    .clock(clock), .reset_n(reset_n), .in_p(in_p), .in_n(in_n),
    .out_p(out_p), .out_n(out_n), .mode(mode), .lane_mask(lane_mask),
    .rate(rate), .burst_len(burst_len), .burst_period(burst_period),
    .trigger(trigger), .stop(stop), .clear(clear), .busy(busy)
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
    , .errors(err_main)
`endif
  );

  lane_error_injector #(.LANES(LANES), .CNT_W(4), .SEED(16'hACE1)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_p(in_p), .in_n(in_n),
    .out_p(out_p4), .out_n(out_n4), .mode(mode), .lane_mask(lane_mask),
    .rate(rate), .burst_len(burst_len), .burst_period(burst_period),
    .trigger(trigger), .stop(stop), .clear(clear), .busy(busy4)
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
    , .errors(err_sat)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  mask;
    logic [15:0] rate;
    logic [7:0]  len;
    logic [15:0] per;
    logic        stop;
    logic [3:0]  ip;
    logic [3:0]  inn;
    logic [3:0]  ep;
    logic [3:0]  en;
    logic        busy;
  } vec_t;

  vec_t tbl[11];

  int         shots, bsy_cnt, bad, comp_bad;
  int         hits[LANES];
  logic [3:0] exp_inj;
  logic       trig_seq[34];

  initial begin
    tbl[0]  = '{2'd0, 4'hF,    16'd0, 8'd0, 16'd0, 1'b0, 4'b1010, 4'b0101, 4'b1010, 4'b0101, 1'b0};
    tbl[1]  = '{2'd2, 4'hF,    16'd0, 8'd4, 16'd4, 1'b0, 4'b1010, 4'b0101, 4'b0101, 4'b1010, 1'b1};
    tbl[2]  = '{2'd2, 4'b0011, 16'd0, 8'd9, 16'd4, 1'b0, 4'b1100, 4'b0011, 4'b1111, 4'b0000, 1'b1};
    tbl[3]  = '{2'd2, 4'hF,    16'd0, 8'd0, 16'd4, 1'b0, 4'b0110, 4'b1001, 4'b0110, 4'b1001, 1'b0};
    tbl[4]  = '{2'd2, 4'hF,    16'd0, 8'd5, 16'd0, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1};
    tbl[5]  = '{2'd2, 4'hF,    16'd0, 8'd4, 16'd4, 1'b1, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 1'b0};
    tbl[6]  = '{2'd2, 4'h0,    16'd0, 8'd4, 16'd4, 1'b0, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 1'b1};
    tbl[7]  = '{2'd1, 4'hF,    16'd0, 8'd0, 16'd0, 1'b0, 4'b1001, 4'b0110, 4'b1001, 4'b0110, 1'b0};
    tbl[8]  = '{2'd3, 4'hF,    16'd0, 8'd0, 16'd0, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b0};
    tbl[9]  = '{2'd2, 4'b1000, 16'd0, 8'd4, 16'd4, 1'b0, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 1'b1};
    tbl[10] = '{2'd0, 4'hF,    16'd0, 8'd4, 16'd4, 1'b0, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 1'b0};

    for (int k = 0; k < 34; k++) trig_seq[k] = (k < 20) || (k == 23) || (k == 25);

    in_p = 4'b1010; in_n = 4'b0101; mode = 2'd0; lane_mask = 4'hF; rate = 16'd0;
    burst_len = 8'd0; burst_period = 16'd0; trigger = 1'b0; stop = 1'b0; clear = 1'b0;

    // reset state
    tick(); tick(); samp();
    chk("rst_out_p", 32'(out_p), 32'(in_p));
    chk("rst_out_n", 32'(out_n), 32'(in_n));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lfsr", 32'(dut.u_lfsr.value), 32'h0000ACE1);
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
    chk("rst_errors", 32'(err_main[31:0] | err_main[127:96]), 32'd0);
`endif
    tick();
    reset_n = 1'b1;

    // steady-state vector table
    for (int k = 0; k < 11; k++) begin
      tick();
      mode = tbl[k].mode; lane_mask = tbl[k].mask; rate = tbl[k].rate;
      burst_len = tbl[k].len; burst_period = tbl[k].per; stop = tbl[k].stop;
      in_p = tbl[k].ip; in_n = tbl[k].inn;
      repeat (3) tick();
      samp();
      chk($sformatf("vec%0d_out_p", k), 32'(out_p), 32'(tbl[k].ep));
      chk($sformatf("vec%0d_out_n", k), 32'(out_n), 32'(tbl[k].en));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
      chk($sformatf("vec%0d_out_p4", k), 32'(out_p4), 32'(tbl[k].ep));
      chk($sformatf("vec%0d_out_n4", k), 32'(out_n4), 32'(tbl[k].en));
      chk($sformatf("vec%0d_busy4", k), 32'(busy4), 32'(tbl[k].busy));
    end

    // RANDOM with rate 0 never injects
    tick(); clear = 1'b1; mode = 2'd1; rate = 16'd0; lane_mask = 4'hF; stop = 1'b0;
    tick(); clear = 1'b0;
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      in_p = 4'(k); in_n = ~4'(k);
      samp();
      if (out_p !== in_p || out_n !== in_n) bad++;
      tick();
    end
    chk("rand0_out", 32'(bad), 32'd0);
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
    for (int l = 0; l < LANES; l++) chk($sformatf("rand0_err%0d", l), err_main[l*32 +: 32], 32'd0);
`endif

    // RANDOM rate 1/4 over one full LFSR period: every nonzero value appears once,
    // so each rotated lane sees exactly 16383 values below 16'h4000
    rate = 16'h4000;
    repeat (3) tick();
    comp_bad = 0;
    for (int l = 0; l < LANES; l++) hits[l] = 0;
    for (int k = 0; k < 65535; k++) begin
      in_p = 4'(k * 7); in_n = ~4'(k * 7);
      samp();
      for (int l = 0; l < LANES; l++) if (out_p[l] !== in_p[l]) hits[l]++;
      if (out_n !== ~out_p) comp_bad++;
      tick();
    end
    for (int l = 0; l < LANES; l++) chk($sformatf("rand25_hits%0d", l), 32'(hits[l]), 32'd16383);
    chk("rand25_complementary", 32'(comp_bad), 32'd0);

    // BURST len 3 period 8 on lanes 0 and 2
    mode = 2'd0;
    repeat (3) tick();
    mode = 2'd2; burst_len = 8'd3; burst_period = 16'd8; lane_mask = 4'b0101; clear = 1'b1;
    tick(); clear = 1'b0;
    tick();
    for (int k = 0; k < 80; k++) begin
      in_p = 4'(k) ^ 4'b0110; in_n = ~in_p;
      samp();
      exp_inj = ((k % 8) < 3) ? 4'b0101 : 4'b0000;
      chk($sformatf("burst_c%0d_out_p", k), 32'(out_p), 32'(in_p ^ exp_inj));
      chk($sformatf("burst_c%0d_busy", k), 32'(busy), 32'((k % 8) < 3));
      tick();
    end
    samp();
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
    chk("burst_err0", err_main[31:0], 32'd30);
    chk("burst_err1", err_main[63:32], 32'd0);
    chk("burst_err2", err_main[95:64], 32'd30);
    chk("burst_err3", err_main[127:96], 32'd0);
`endif

    // asynchronous reset in the middle of a burst
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_p", 32'(out_p), 32'(in_p));
    chk("midrst_out_n", 32'(out_n), 32'(in_n));
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_lfsr0", 32'(dut.u_lfsr.value), 32'h0000ACE1);
    @(negedge clock);
    reset_n = 1'b1;
    tick(); chk("midrst_lfsr1", 32'(dut.u_lfsr.value), 32'h0000E270);
    tick(); chk("midrst_lfsr2", 32'(dut.u_lfsr.value), 32'h00007138);
    tick(); chk("midrst_lfsr3", 32'(dut.u_lfsr.value), 32'h0000389C);

    // SINGLE: held trigger, then a pulse, then a pulse landing in HOLD
    mode = 2'd0; lane_mask = 4'hF;
    repeat (3) tick();
    clear = 1'b1; mode = 2'd3; trigger = 1'b0;
    tick(); clear = 1'b0;
    repeat (3) tick();
    shots = 0; bsy_cnt = 0; bad = 0;
    for (int k = 0; k < 34; k++) begin
      trigger = trig_seq[k];
      in_p = 4'(k); in_n = ~4'(k);
      samp();
      if ((out_p ^ in_p) != 4'b0000) begin
        shots++;
        if ((out_p ^ in_p) != 4'hF || (out_n ^ in_n) != 4'hF) bad++;
      end
      if (busy) bsy_cnt++;
      tick();
    end
    chk("single_shots", 32'(shots), 32'd2);
    chk("single_busy_cycles", 32'(bsy_cnt), 32'd2);
    chk("single_shot_shape", 32'(bad), 32'd0);
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
    for (int l = 0; l < LANES; l++) chk($sformatf("single_err%0d", l), err_main[l*32 +: 32], 32'd2);
`endif

    // continuous burst into 4-bit counters: saturation, clear, stop hold
    mode = 2'd0;
    repeat (3) tick();
    mode = 2'd2; burst_len = 8'd8; burst_period = 16'd8; lane_mask = 4'hF; clear = 1'b1;
    tick(); clear = 1'b0;
    repeat (22) tick();
    samp();
    chk("sat_busy", 32'(busy4), 32'd1);
`ifdef LANE_ERROR_INJECTOR_COUNT_EN
    chk("sat_err_at20", 32'(err_sat), 32'hFFFF);
    repeat (5) tick();
    samp();
    chk("sat_err_hold", 32'(err_sat), 32'hFFFF);
    tick(); clear = 1'b1;
    tick(); clear = 1'b0;
    samp();
    chk("sat_err_clear", 32'(err_sat), 32'h0000);
    tick();
    samp();
    chk("sat_err_resume", 32'(err_sat), 32'h1111);
    stop = 1'b1;
    repeat (4) tick();
    samp();
    chk("sat_err_stop_hold", 32'(err_sat), 32'h1111);
    chk("stop_out_p", 32'(out_p4), 32'(in_p));
    stop = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, err_cnt);
    $finish;
  end

endmodule
